cmd_queue_rr: RTL and testbench
===============================

Name: cmd_queue_rr

Overview:
Multi-channel command queue. Successor to the single-channel, testbench-preloaded command FIFO that feeds the issuer in top.
NUM_CH independent producers each write commands into their own circular buffer. One issuer-facing read port serves non-empty channels in round-robin order, and each delivered command is tagged with its source channel.
Adds per-channel occupancy, a sticky overflow flag, and a drained indication. Sits between command sources (loader, host, recompose unit) and the issuer.

Parameters:
WIDTH, 64, command word width in bits (set to $bits(cmd_t) at instantiation)
DEPTH, 16, entries per channel; must be a power of two and at least 2
NUM_CH, 4, number of producer channels; at least 1
AW, $clog2(DEPTH), derived: pointer width
CHW, (NUM_CH>1 ? $clog2(NUM_CH) : 1), derived: channel tag width

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst  in  1  synchronous reset, active-high
i_wr  in  NUM_CH  per-channel write strobe
i_wr_data  in  NUM_CH*WIDTH  per-channel write data; channel c occupies bits [c*WIDTH +: WIDTH]
o_full  out  NUM_CH  channel c holds DEPTH entries
o_count  out  NUM_CH*(AW+1)  per-channel occupancy, range 0..DEPTH
o_overflow  out  NUM_CH  sticky: a write arrived while that channel was full
i_clr_ovf  in  1  clears all o_overflow bits
i_read  in  1  issuer pops the presented command
o_data  out  WIDTH  presented command, first-word-fall-through
o_ch  out  CHW  source channel of o_data
o_empty  out  1  no channel holds data
o_drained  out  1  registered; set once all channels are empty after at least one read since reset

Behaviour:
- Reset (i_rst=1 at a clock edge), applied to all state:
  - all pointers and counts go to 0;
  - o_full=0, o_overflow=0, o_empty=1, o_drained=0;
  - round-robin pointer rr=0;
  - o_data and o_ch are don't-care while o_empty=1, but the implementation drives o_data=0 and o_ch=0;
  - reset during operation discards all queued commands, with no partial pop or push;
  - storage RAM contents are not cleared.
- Write, per channel c:
  - if i_wr[c] is high and the channel is not full (or is full and is popped in the same cycle), the word is stored at the write pointer and the write pointer increments modulo DEPTH;
  - a write to a full channel with no same-cycle pop is dropped, o_overflow[c] is set, and the count is unchanged.
- Selection (combinational):
  - sel = the first channel with count>0, searching from rr upward with wrap-around;
  - o_data = head of sel; o_ch = sel; o_empty = (all counts 0).
- Read:
  - i_read with o_empty=0 pops the head of sel: its read pointer increments and its count decrements;
  - rr is then set to (sel+1) mod NUM_CH;
  - i_read with o_empty=1 is ignored: no state change, rr unchanged;
  - with no read, rr holds.
- Simultaneous push and pop on the same channel: count unchanged, and both pointers advance.
  - This is legal when the channel is full: the write is accepted and no overflow is flagged.
  - On an empty channel there is no pop, so the write simply lands.
- Latency: a word written at edge N is visible on o_data after edge N (first-word-fall-through), provided that channel wins the selection.
- Fairness: with K channels continuously non-empty, each is served exactly once per K reads.
- Ordering: FIFO order is preserved within a channel; there is no ordering guarantee across channels.
- Counts: o_full[c] = (count==DEPTH). Count width is AW+1; pointers wrap at DEPTH with no special case.
- o_overflow: i_clr_ovf clears all bits. An overflow event in the same cycle as i_clr_ovf wins, so the bit ends up set.
- o_drained:
  - set at the edge following a cycle where a successful read leaves all counts 0 and no write is accepted in that cycle;
  - cleared by any accepted write.

Test Plan:
- Reset then idle: o_empty=1, o_count all 0, o_drained=0. A read on the empty queue leaves rr=0 and counts at 0.
- Single channel FIFO order, DEPTH=16: write 0x11..0x1F plus 0x20 on ch2 → o_full[2]=1, count=16. A 17th write sets o_overflow[2]. 16 reads return 0x11..0x20 in order with o_ch=2. o_drained=1 after the last read.
- Round-robin: ch0={A0,A1}, ch1={B0}, ch3={D0,D1}, hold i_read=1 → output sequence A0,B0,D0,A1,D1, then o_empty=1.
- Full-channel push+pop: ch1 full, i_wr[1]=1 and i_read=1 with sel=1 in the same cycle → count stays 16, o_overflow[1] stays 0, and the new word appears after 15 further pops.
- Overflow vs clear: write to full ch0 with i_clr_ovf=1 in the same cycle → o_overflow[0]=1. The next cycle with i_clr_ovf=1 only → 0.
- Reset mid-stream: ch0 holds 5 entries, ch3 holds 3 entries, assert i_rst for one cycle → all counts 0, o_empty=1, rr=0. Writing 0x55 on ch3 next → o_data=0x55 and o_ch=3 one edge later.

Source files
------------

// File: rtl/cmd_queue_rr.sv
// cmd_queue_rr
// Multi-channel command queue. Each of NUM_CH producers writes into its own
// circular buffer of DEPTH entries. A single first-word-fall-through read port
// serves the non-empty channels in round-robin order. Each delivered command is
// tagged with the channel it came from.
//
// Ports
//   i_clk       clock; all state updates on the rising edge
//   i_rst       synchronous reset, active-high
//   i_wr        per-channel write strobe
//   i_wr_data   per-channel write data; channel c at [c*WIDTH +: WIDTH]
//   o_full      channel c holds DEPTH entries
//   o_count     per-channel occupancy (AW+1 bits each), 0..DEPTH
//   o_overflow  sticky per-channel flag: a write was dropped because the channel was full
//   i_clr_ovf   clears all overflow bits
//   i_read      pop the presented command
//   o_data      presented command (head of the selected channel)
//   o_ch        source channel of o_data
//   o_empty     no channel holds data
//   o_drained   set once a read empties every channel; cleared by any accepted write
//
// Handshake: o_data/o_ch are valid whenever o_empty=0. A pop happens on a
// rising edge where i_read=1 and o_empty=0. i_read while o_empty=1 is ignored.
// Writes need no handshake. A write to a full channel is dropped unless the same
// channel is popped in that cycle.
module cmd_queue_rr #(
  parameter  int WIDTH  = 64,
  parameter  int DEPTH  = 16,
  parameter  int NUM_CH = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_CH-1:0]        i_wr,
  input  logic [NUM_CH*WIDTH-1:0]  i_wr_data,
  output logic [NUM_CH-1:0]        o_full,
  output logic [NUM_CH*(AW+1)-1:0] o_count,
  output logic [NUM_CH-1:0]        o_overflow,
  input  logic                     i_clr_ovf,
  input  logic                     i_read,
  output logic [WIDTH-1:0]         o_data,
  output logic [CHW-1:0]           o_ch,
  output logic                     o_empty,
  output logic                     o_drained
);

  // Storage is deliberately left without a reset.
  logic [WIDTH-1:0] r_mem  [NUM_CH][DEPTH];
  logic [AW-1:0]    r_wptr [NUM_CH];
  logic [AW-1:0]    r_rptr [NUM_CH];
  logic [AW:0]      r_cnt  [NUM_CH];
  logic [NUM_CH-1:0] r_ovf;
  logic [CHW-1:0]   r_rr;
  logic             r_drained;

  logic [NUM_CH-1:0] w_nonempty;
  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_pop_ch;
  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_ovf_ev;
  logic [AW:0]       w_cnt_nxt [NUM_CH];
  logic [CHW-1:0]    w_sel;
  logic [CHW-1:0]    w_rr_nxt;
  logic              w_any;
  logic              w_pop;
  logic              w_all_zero_nxt;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_nonempty[c] = (r_cnt[c] != '0);
      w_full[c]     = (r_cnt[c] == (AW+1)'(DEPTH));
    end
  end

  // Round-robin search: first non-empty channel at or after r_rr, with wrap-around.
  always_comb begin
    int idx;
    w_sel = '0;
    w_any = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(r_rr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!w_any && w_nonempty[idx]) begin
        w_any = 1'b1;
        w_sel = CHW'(idx);
      end
    end
  end

  assign w_pop    = i_read && w_any;
  assign w_rr_nxt = (int'(w_sel) == NUM_CH - 1) ? '0 : w_sel + CHW'(1);

  // A full channel can still take a write when it is popped in the same cycle.
  always_comb begin
    w_all_zero_nxt = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      w_pop_ch[c]  = w_pop && (int'(w_sel) == c);
      w_push[c]    = i_wr[c] && (!w_full[c] || w_pop_ch[c]);
      w_ovf_ev[c]  = i_wr[c] && w_full[c] && !w_pop_ch[c];
      w_cnt_nxt[c] = r_cnt[c] + (AW+1)'(w_push[c]) - (AW+1)'(w_pop_ch[c]);
      if (w_cnt_nxt[c] != '0) w_all_zero_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
        r_cnt[c]  <= '0;
      end
      r_ovf     <= '0;
      r_rr      <= '0;
      r_drained <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_push[c])   r_wptr[c] <= r_wptr[c] + AW'(1);
        if (w_pop_ch[c]) r_rptr[c] <= r_rptr[c] + AW'(1);
        r_cnt[c] <= w_cnt_nxt[c];
        // A new overflow beats a simultaneous clear.
        if (w_ovf_ev[c])    r_ovf[c] <= 1'b1;
        else if (i_clr_ovf) r_ovf[c] <= 1'b0;
      end
      if (w_pop) r_rr <= w_rr_nxt;
      if (|w_push)                      r_drained <= 1'b0;
      else if (w_pop && w_all_zero_nxt) r_drained <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!i_rst && w_push[c]) r_mem[c][r_wptr[c]] <= i_wr_data[c*WIDTH +: WIDTH];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_count
    assign o_count[g*(AW+1) +: AW+1] = r_cnt[g];
  end

  assign o_full     = w_full;
  assign o_overflow = r_ovf;
  assign o_empty    = !w_any;
  assign o_ch       = w_sel;
  assign o_data     = w_any ? r_mem[w_sel][r_rptr[w_sel]] : '0;
  assign o_drained  = r_drained;

endmodule

// File: tb/tb_cmd_queue_rr.sv
module tb_cmd_queue_rr;
  localparam int WIDTH  = 16;
  localparam int DEPTH  = 16;
  localparam int NUM_CH = 4;
  localparam int AW     = 4;
  localparam int CHW    = 2;
  localparam int EW     = CHW + WIDTH;

  logic                     clk;
  logic                     i_rst;
  logic [NUM_CH-1:0]        i_wr;
  logic [NUM_CH*WIDTH-1:0]  i_wr_data;
  logic [NUM_CH-1:0]        o_full;
  logic [NUM_CH*(AW+1)-1:0] o_count;
  logic [NUM_CH-1:0]        o_overflow;
  logic                     i_clr_ovf;
  logic                     i_read;
  logic [WIDTH-1:0]         o_data;
  logic [CHW-1:0]           o_ch;
  logic                     o_empty;
  logic                     o_drained;

  int n_total = 0;
  int n_bad   = 0;
  logic [EW-1:0] exp_q[$];

  cmd_queue_rr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_wr(i_wr), .i_wr_data(i_wr_data),
    .o_full(o_full), .o_count(o_count), .o_overflow(o_overflow),
    .i_clr_ovf(i_clr_ovf), .i_read(i_read), .o_data(o_data), .o_ch(o_ch),
    .o_empty(o_empty), .o_drained(o_drained)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  // driver tasks
  task automatic wr1(input int c, input logic [WIDTH-1:0] d);
    i_wr = NUM_CH'(1) << c;
    i_wr_data[c*WIDTH +: WIDTH] = d;
    tick();
    i_wr = '0;
  endtask

  task automatic wr_multi(input logic [NUM_CH-1:0] m, input logic [NUM_CH*WIDTH-1:0] d);
    i_wr = m;
    i_wr_data = d;
    tick();
    i_wr = '0;
  endtask

  task automatic read_n(input int n);
    i_read = 1'b1;
    repeat (n) tick();
    i_read = 1'b0;
  endtask

  task automatic expect_pop(input int c, input logic [WIDTH-1:0] d);
    exp_q.push_back({CHW'(c), d});
  endtask

  function automatic logic [AW:0] cnt(input int c);
    return o_count[c*(AW+1) +: AW+1];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // scoreboard monitor: every accepted pop is compared with the expected queue
  always @(negedge clk) begin
    if (!i_rst && i_read && !o_empty) begin
      n_total++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pop: got ch=%0d data=0x%0h expected nothing", o_ch, o_data);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({o_ch, o_data} !== e) begin
          n_bad++;
          $display("FAIL pop_order: got ch=%0d data=0x%0h expected ch=%0d data=0x%0h",
                   o_ch, o_data, e[EW-1 -: CHW], e[WIDTH-1:0]);
        end
      end
    end
  end

  initial begin
    i_rst = 1'b0; i_wr = '0; i_wr_data = '0; i_clr_ovf = 1'b0; i_read = 1'b0;
    @(negedge clk);
    i_rst = 1'b1;
    tick(); tick();
    i_rst = 1'b0;

    // reset state
    check("rst_empty", 64'(o_empty), 64'd1);
    check("rst_count", 64'(o_count), 64'd0);
    check("rst_drained", 64'(o_drained), 64'd0);
    check("rst_full", 64'(o_full), 64'd0);
    check("rst_ovf", 64'(o_overflow), 64'd0);
    check("rst_data", 64'(o_data), 64'd0);
    check("rst_ch", 64'(o_ch), 64'd0);

    // read on empty queue changes nothing; rr must still be 0
    read_n(1);
    check("empty_read_empty", 64'(o_empty), 64'd1);
    check("empty_read_count", 64'(o_count), 64'd0);
    check("empty_read_drained", 64'(o_drained), 64'd0);
    wr_multi(4'b0011, {16'h0, 16'h0, 16'h0202, 16'h0101});
    check("rr0_ch", 64'(o_ch), 64'd0);
    check("rr0_data", 64'(o_data), 64'h0101);
    expect_pop(0, 16'h0101);
    expect_pop(1, 16'h0202);
    read_n(2);
    check("two_drained", 64'(o_drained), 64'd1);
    check("two_empty", 64'(o_empty), 64'd1);

    // single channel FIFO order on ch2, fill, overflow
    for (int k = 0; k < 16; k++) wr1(2, 16'h11 + 16'(k));
    check("ch2_full", 64'(o_full), 64'b0100);
    check("ch2_count", 64'(cnt(2)), 64'd16);
    check("ch2_drained_clr", 64'(o_drained), 64'd0);
    check("ch2_no_ovf", 64'(o_overflow), 64'd0);
    wr1(2, 16'h99);
    check("ch2_ovf", 64'(o_overflow), 64'b0100);
    check("ch2_count_ovf", 64'(cnt(2)), 64'd16);
    for (int k = 0; k < 16; k++) expect_pop(2, 16'h11 + 16'(k));
    read_n(16);
    check("ch2_drained", 64'(o_drained), 64'd1);
    check("ch2_empty", 64'(o_empty), 64'd1);
    check("ch2_ovf_sticky", 64'(o_overflow), 64'b0100);
    i_clr_ovf = 1'b1; tick(); i_clr_ovf = 1'b0;
    check("ch2_ovf_clr", 64'(o_overflow), 64'd0);

    // round-robin from rr=0
    do_reset();
    check("rr_rst_drained", 64'(o_drained), 64'd0);
    wr_multi(4'b1011, {16'hD0, 16'h0, 16'hB0, 16'hA0});
    wr_multi(4'b1001, {16'hD1, 16'h0, 16'h0, 16'hA1});
    expect_pop(0, 16'hA0);
    expect_pop(1, 16'hB0);
    expect_pop(3, 16'hD0);
    expect_pop(0, 16'hA1);
    expect_pop(3, 16'hD1);
    read_n(5);
    check("rr_empty", 64'(o_empty), 64'd1);
    check("rr_drained", 64'(o_drained), 64'd1);

    // full channel push + pop in the same cycle
    for (int k = 0; k < 16; k++) wr1(1, 16'h100 + 16'(k));
    check("pp_count_pre", 64'(cnt(1)), 64'd16);
    for (int k = 0; k < 16; k++) expect_pop(1, 16'h100 + 16'(k));
    expect_pop(1, 16'h1FF);
    i_wr = 4'b0010;
    i_wr_data[1*WIDTH +: WIDTH] = 16'h1FF;
    i_read = 1'b1;
    tick();
    i_wr = '0;
    i_read = 1'b0;
    check("pp_count", 64'(cnt(1)), 64'd16);
    check("pp_no_ovf", 64'(o_overflow), 64'd0);
    check("pp_full", 64'(o_full), 64'b0010);
    read_n(16);
    check("pp_empty", 64'(o_empty), 64'd1);

    // overflow event beats a simultaneous clear
    for (int k = 0; k < 16; k++) wr1(0, 16'h300 + 16'(k));
    i_clr_ovf = 1'b1;
    wr1(0, 16'h3FF);
    check("ovf_vs_clr", 64'(o_overflow), 64'b0001);
    tick();
    i_clr_ovf = 1'b0;
    check("clr_only", 64'(o_overflow), 64'd0);
    check("ovf_count", 64'(cnt(0)), 64'd16);

    // reset mid-stream with rr != 0
    do_reset();
    for (int k = 0; k < 3; k++)
      wr_multi(4'b1001, {16'h430 + 16'(k), 16'h0, 16'h0, 16'h400 + 16'(k)});
    for (int k = 3; k < 6; k++) wr1(0, 16'h400 + 16'(k));
    expect_pop(0, 16'h400);
    read_n(1);
    check("mid_cnt0", 64'(cnt(0)), 64'd5);
    check("mid_cnt3", 64'(cnt(3)), 64'd3);
    check("mid_sel", 64'(o_ch), 64'd3);
    do_reset();
    check("mid_rst_count", 64'(o_count), 64'd0);
    check("mid_rst_empty", 64'(o_empty), 64'd1);
    check("mid_rst_data", 64'(o_data), 64'd0);
    wr1(3, 16'h55);
    check("post_rst_data", 64'(o_data), 64'h55);
    check("post_rst_ch", 64'(o_ch), 64'd3);
    wr1(0, 16'h66);
    check("post_rst_rr0", 64'(o_ch), 64'd0);
    expect_pop(0, 16'h66);
    expect_pop(3, 16'h55);
    read_n(2);
    check("final_empty", 64'(o_empty), 64'd1);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // safety net against a stuck simulation
  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected finish");
    $fatal(1);
  end
endmodule
